// File: rtl/gcd_req_driver_if.sv
// Start/done handshake between the batch driver (master) and a sequential GCD core (slave).
// Operands and start flow toward the core, the result and done flow back.
interface gcd_req_driver_if #(
  parameter int W = 8
);
  logic [W-1:0] core_a;
  logic [W-1:0] core_b;
  logic         core_start;
  logic [W-1:0] core_gcd;
  logic         core_done;

  modport master (
    output core_a,
    output core_b,
    output core_start,
    input  core_gcd,
    input  core_done
  );

  modport slave (
    input  core_a,
    input  core_b,
    input  core_start,
    output core_gcd,
    output core_done
  );
endinterface

// File: rtl/gcd_req_driver.sv
// Batch initiator for a sequential GCD core: issues a host-loaded table of operand pairs one by
// one over a level start/done handshake and records each result with a per-entry timeout flag.
module gcd_req_driver #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [AW-1:0]    i_ld_addr,
  input  logic [W-1:0]     i_ld_a,
  input  logic [W-1:0]     i_ld_b,
  input  logic             i_go,
  output logic             o_busy,
  output logic             o_finished,
  output logic [AW:0]      o_err_count,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [W-1:0]     o_rd_gcd,
  output logic             o_rd_err,
  gcd_req_driver_if.master core
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RELEASE,
    S_FINISH
  } state_t;

  localparam logic [15:0]   TIMEOUT_L = 16'(TIMEOUT);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_op_a [DEPTH];
  logic [W-1:0]  r_op_b [DEPTH];
  logic [W-1:0]  r_res  [DEPTH];
  logic [DEPTH-1:0] r_err;

  logic [AW-1:0] r_idx;
  logic [15:0]   r_timer;
  logic [AW:0]   r_err_count;
  logic [W-1:0]  r_core_a;
  logic [W-1:0]  r_core_b;
  logic          r_core_start;
  logic          r_busy;
  logic          r_finished;

  logic          w_issue;
  logic          w_capture;
  logic          w_timeout;
  logic          w_tick;
  logic          w_ld_en;
  logic          w_fwd;
  logic          w_go;
  logic [AW-1:0] w_issue_idx;
  logic [W-1:0]  w_issue_a;
  logic [W-1:0]  w_issue_b;

  // A write in the same cycle as go must reach the core, so the issued pair bypasses the table.
  assign w_ld_en     = i_load && (r_state == S_IDLE);
  assign w_issue_idx = (r_state == S_IDLE) ? '0 : r_idx + 1'b1;
  assign w_fwd       = w_ld_en && (i_ld_addr == w_issue_idx);
  assign w_issue_a   = w_fwd ? i_ld_a : r_op_a[w_issue_idx];
  assign w_issue_b   = w_fwd ? i_ld_b : r_op_b[w_issue_idx];
  assign w_go        = w_issue && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_tick      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_go) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core.core_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if (r_timer == TIMEOUT_L) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RELEASE;
        end else begin
          w_tick      = 1'b1;
        end
      end
      S_RELEASE: begin
        // A core that keeps done high must drop it first, or its stale done ends the next entry.
        if (!core.core_done || r_err[r_idx]) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tables are reset too, because the host must read back zeros after reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_op_a[i] <= '0;
        r_op_b[i] <= '0;
        r_res[i]  <= '0;
      end
      r_err        <= '0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_err_count  <= '0;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_finished   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (w_ld_en) begin
        r_op_a[i_ld_addr] <= i_ld_a;
        r_op_b[i_ld_addr] <= i_ld_b;
      end
      if (w_go) begin
        r_err       <= '0;
        r_err_count <= '0;
      end
      if (w_issue) begin
        r_idx    <= w_issue_idx;
        r_core_a <= w_issue_a;
        r_core_b <= w_issue_b;
        r_timer  <= '0;
      end
      if (w_tick) r_timer <= r_timer + 16'd1;
      if (w_capture) begin
        r_res[r_idx] <= core.core_gcd;
        r_err[r_idx] <= 1'b0;
      end
      if (w_timeout) begin
        r_res[r_idx] <= '0;
        r_err[r_idx] <= 1'b1;
        r_err_count  <= r_err_count + 1'b1;
      end
      r_core_start <= (w_state_nxt == S_WAIT);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_finished   <= (w_state_nxt == S_FINISH);
    end
  end

  assign core.core_a     = r_core_a;
  assign core.core_b     = r_core_b;
  assign core.core_start = r_core_start;

  assign o_busy      = r_busy;
  assign o_finished  = r_finished;
  assign o_err_count = r_err_count;
  assign o_rd_gcd    = r_res[i_rd_addr];
  assign o_rd_err    = r_err[i_rd_addr];

endmodule

// File: tb/tb_gcd_req_driver.sv
// Directed bench for gcd_req_driver against a behavioural subtractive GCD core whose
// done-hold time and per-entry hang can be set per batch.
module tb_gcd_req_driver;
  localparam int W       = 8;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;
  localparam int TIMEOUT = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_load;
  logic [AW-1:0] i_ld_addr;
  logic [W-1:0]  i_ld_a;
  logic [W-1:0]  i_ld_b;
  logic          i_go;
  logic          o_busy;
  logic          o_finished;
  logic [AW:0]   o_err_count;
  logic [AW-1:0] i_rd_addr;
  logic [W-1:0]  o_rd_gcd;
  logic          o_rd_err;

  gcd_req_driver_if #(.W(W)) cif ();

  gcd_req_driver #(.W(W), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_load      (i_load),
    .i_ld_addr   (i_ld_addr),
    .i_ld_a      (i_ld_a),
    .i_ld_b      (i_ld_b),
    .i_go        (i_go),
    .o_busy      (o_busy),
    .o_finished  (o_finished),
    .o_err_count (o_err_count),
    .i_rd_addr   (i_rd_addr),
    .o_rd_gcd    (o_rd_gcd),
    .o_rd_err    (o_rd_err),
    .core        (cif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural core: 0 idle, 1 computing, 2 done held, 3 hung (never answers).
  int           cm_st;
  int           hold;
  int           sticky;
  logic [W-1:0] cx, cy;
  logic [1:0]   cm_ent;
  logic [3:0]   hang_mask;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cm_st         <= 0;
      hold          <= 0;
      cm_ent        <= '0;
      cif.core_done <= 1'b0;
      cif.core_gcd  <= '0;
    end else begin
      case (cm_st)
        0: if (cif.core_start) begin
             cx     <= cif.core_a;
             cy     <= cif.core_b;
             cm_st  <= hang_mask[cm_ent] ? 3 : 1;
             cm_ent <= cm_ent + 2'd1;
           end
        1: if (cx == cy) begin
             cif.core_gcd  <= cx;
             cif.core_done <= 1'b1;
             hold          <= 0;
             cm_st         <= 2;
           end else if (cx > cy) cx <= cx - cy;
           else                  cy <= cy - cx;
        2: if (!cif.core_start) begin
             if (hold == sticky) begin
               cif.core_done <= 1'b0;
               cm_st         <= 0;
             end else hold <= hold + 1;
           end
        3: if (!cif.core_start) cm_st <= 0;
        default: cm_st <= 0;
      endcase
    end
  end

  // Handshake monitor: start rises, rises while done is still high, high-run lengths, low gaps.
  int   n_rise = 0, n_fin = 0, n_bad = 0;
  int   run_len = 0, gap = 0;
  int   min_run, max_run, min_gap;
  logic seen_fall;
  logic prev_s = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      prev_s  <= 1'b0;
      run_len <= 0;
      gap     <= 0;
    end else begin
      prev_s <= cif.core_start;
      if (o_finished) n_fin <= n_fin + 1;
      if (cif.core_start) begin
        run_len <= run_len + 1;
        if (!prev_s) begin
          n_rise <= n_rise + 1;
          if (cif.core_done) n_bad <= n_bad + 1;
          if (seen_fall && gap < min_gap) min_gap <= gap;
        end
      end else if (prev_s) begin
        if (run_len < min_run) min_run <= run_len;
        if (run_len > max_run) max_run <= run_len;
        run_len   <= 0;
        seen_fall <= 1'b1;
        gap       <= 1;
      end else begin
        gap <= gap + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clr();
    min_run   = 1000;
    max_run   = 0;
    min_gap   = 1000;
    seen_fall = 1'b0;
  endtask

  task automatic load_pair(input int addr, input int a, input int b);
    i_load    = 1'b1;
    i_ld_addr = AW'(addr);
    i_ld_a    = W'(a);
    i_ld_b    = W'(b);
    tick();
    i_load    = 1'b0;
  endtask

  task automatic load_set(input int a0, b0, a1, b1, a2, b2, a3, b3);
    load_pair(0, a0, b0);
    load_pair(1, a1, b1);
    load_pair(2, a2, b2);
    load_pair(3, a3, b3);
  endtask

  // Pulses go (with any load already on the bus), optionally pokes go+load mid-batch, waits for finished.
  task automatic go_and_wait(input string tag, input bit poke);
    bit seen = 1'b0;
    int r0   = n_rise;
    int f0   = n_fin;
    i_go = 1'b1;
    tick();
    i_go   = 1'b0;
    i_load = 1'b0;
    check({tag, "_busy_after_go"}, o_busy, 1);
    check({tag, "_start_after_go"}, cif.core_start, 1);
    for (int c = 0; c < 400 && !seen; c++) begin
      if (poke && c == 3) begin
        i_go = 1'b1; i_load = 1'b1; i_ld_addr = '0; i_ld_a = 8'd9; i_ld_b = 8'd3;
      end else begin
        i_go = 1'b0; i_load = 1'b0;
      end
      tick();
      if (o_finished) seen = 1'b1;
    end
    i_go = 1'b0; i_load = 1'b0;
    check({tag, "_finished_seen"}, seen, 1);
    tick();
    check({tag, "_idle_after_finish"}, {o_busy, o_finished}, 0);
    check({tag, "_start_count"}, n_rise - r0, DEPTH);
    check({tag, "_finish_pulses"}, n_fin - f0, 1);
  endtask

  task automatic check_results(input string tag, input logic [4*W-1:0] exp_g,
                               input logic [3:0] exp_e, input int exp_cnt);
    for (int i = 0; i < DEPTH; i++) begin
      i_rd_addr = AW'(i);
      #1;
      check($sformatf("%s_gcd%0d", tag, i), o_rd_gcd, exp_g[i*W +: W]);
      check($sformatf("%s_err%0d", tag, i), o_rd_err, exp_e[i]);
    end
    check({tag, "_err_count"}, o_err_count, exp_cnt);
  endtask

  initial begin
    bit found;
    int r0;
    rst = 1'b1; i_load = 1'b0; i_go = 1'b0; i_ld_addr = '0; i_ld_a = '0; i_ld_b = '0;
    i_rd_addr = '0; hang_mask = 4'b0000; sticky = 0;
    mon_clr();
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", o_busy, 0);
    check("rst_finished", o_finished, 0);
    check("rst_start", cif.core_start, 0);
    check("rst_core_ab", {cif.core_a, cif.core_b}, 0);
    check_results("rst", '0, 4'b0000, 0);

    // Normal batch, with go and a load to entry 0 poked mid-batch (both must be ignored).
    load_set(24, 16, 25, 15, 7, 13, 100, 75);
    mon_clr();
    go_and_wait("normal", 1'b1);
    check_results("normal", {8'd25, 8'd1, 8'd5, 8'd8}, 4'b0000, 0);
    check("normal_min_gap_ge1", min_gap >= 1 && min_gap < 1000, 1);
    check("normal_no_restart_on_done", n_bad, 0);

    // Every entry times out: 21 WAIT cycles each.
    hang_mask = 4'b1111;
    mon_clr();
    go_and_wait("timeout", 1'b0);
    check_results("timeout", '0, 4'b1111, 4);
    check("timeout_min_wait", min_run, TIMEOUT + 1);
    check("timeout_max_wait", max_run, TIMEOUT + 1);

    // Sticky done; entry 0 must still hold (24,16) despite the ignored mid-batch load.
    hang_mask = 4'b0000;
    sticky    = 5;
    r0        = n_bad;
    go_and_wait("sticky", 1'b0);
    check_results("sticky", {8'd25, 8'd1, 8'd5, 8'd8}, 4'b0000, 0);
    check("sticky_no_restart_on_done", n_bad - r0, 0);

    // Entry 1 hangs, the others answer.
    sticky    = 0;
    hang_mask = 4'b0010;
    go_and_wait("mixed", 1'b0);
    check_results("mixed", {8'd25, 8'd1, 8'd0, 8'd8}, 4'b0010, 1);

    // Reset while entry 2 is in WAIT.
    hang_mask = 4'b0000;
    r0        = n_rise;
    found     = 1'b0;
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (n_rise - r0 == 3 && cif.core_start) found = 1'b1;
    end
    check("rstwait_reached_entry2", found, 1);
    rst = 1'b1;
    #1;
    check("rstwait_start", cif.core_start, 0);
    check("rstwait_busy", o_busy, 0);
    check("rstwait_err_count", o_err_count, 0);
    check("rstwait_core_ab", {cif.core_a, cif.core_b}, 0);
    tick();
    rst = 1'b0;
    check_results("rstwait", '0, 4'b0000, 0);

    // Recovery batch; entry 0 is written in the same cycle as go.
    load_pair(1, 25, 15);
    load_pair(2, 7, 13);
    load_pair(3, 100, 75);
    i_load = 1'b1; i_ld_addr = '0; i_ld_a = 8'd12; i_ld_b = 8'd18;
    go_and_wait("recover", 1'b0);
    check_results("recover", {8'd25, 8'd1, 8'd5, 8'd6}, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gcd_req_driver.md
# gcd_req_driver

Batch initiator for the sequential GCD core's start/done handshake. It holds a small table of operand pairs loaded by the host. On `go` it issues each pair to the GCD core in turn and waits for `done`. It captures each result, with a per-entry timeout flag, into a result table the host reads back. It sits between the host/testbench and the GCD control path, driving the core's `a`, `b` and `start` inputs and consuming its `gcd` and `done` outputs.

## Interface
- `W`, 8: operand/result width.
- `DEPTH`, 4: number of operand pairs per batch; power of two, ≥2.
- `AW`, 2: address width, equal to log2(`DEPTH`).
- `TIMEOUT`, 255: maximum cycles to wait for `done` before flagging an error; ≥1, fits in 16 bits.
- `clk` in 1: single clock; rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: write `ld_a`/`ld_b` into operand entry `ld_addr`; ignored while `busy`=1.
- `ld_addr` in AW: operand write address.
- `ld_a`, `ld_b` in W: operand pair to store.
- `go` in 1: start a batch; sampled only in IDLE.
- `busy` out 1: 1 from the cycle after `go` until FINISH is left.
- `finished` out 1: one-cycle pulse at batch end.
- `err_count` out AW+1: number of timed-out entries in the last batch; cleared on `go`.
- `rd_addr` in AW: result read address.
- `rd_gcd` out W: combinational read of result entry `rd_addr`.
- `rd_err` out 1: combinational read of the timeout flag for `rd_addr`.
- `core_a`, `core_b` out W: operands to the GCD core.
- `core_start` out 1: level request to the GCD core.
- `core_gcd` in W: result from the core.
- `core_done` in 1: completion from the core; may be held high after completion.

## Operation
- Reset values: `busy`=0, `finished`=0, `core_start`=0, `core_a`=`core_b`=0, `err_count`=0. Operand, result and error tables all clear to 0. State is IDLE, `idx`=0, `timer`=0.
- IDLE:
  - `load`=1 writes the operand entry.
  - `go`=1 clears `err_count` and all error flags, sets `idx`=0, loads `core_a`/`core_b` from entry 0, sets `core_start`=1 and `timer`=0, then moves to WAIT.
  - If `go` and `load` occur in the same cycle, the write happens first; the new value is used if the address is 0.
- WAIT (`core_start`=1; `core_a`/`core_b` held stable):
  - `core_done`=1: store `result[idx]`=`core_gcd` and `err[idx]`=0, then go to RELEASE.
  - Otherwise, if `timer`==`TIMEOUT`: store `result[idx]`=0 and `err[idx]`=1, increment `err_count`, then go to RELEASE.
  - Otherwise increment `timer`.
  - If `core_done` and the timeout coincide, `done` wins.
- RELEASE (`core_start`=0):
  - Wait for `core_done`=0, so a core that holds `done` is not double-counted.
  - On a timed-out entry, proceed immediately.
  - If `idx`==`DEPTH`-1, go to FINISH.
  - Otherwise increment `idx`, load the next operands, set `core_start`=1 and `timer`=0, and go to WAIT.
- FINISH: `finished`=1 for exactly one cycle, `busy` drops, then return to IDLE.
- `busy`=1 in WAIT, RELEASE and FINISH; it falls in the cycle after FINISH.
- `go` and `load` are ignored in every state except IDLE (`load` is ignored while `busy`=1).
- Result and error tables persist until the next `go` or reset; results are overwritten per entry.
- `rst` asserted in any state immediately forces `core_start`=0 and all other reset values, abandoning the batch.

## Timing
- All outputs are registered except `rd_gcd` and `rd_err`.
- `go` sampled at edge T: `core_start`=1 with valid operands visible after edge T; `busy`=1 from the same edge.
- `core_done` sampled high at edge D: result written at D; `core_start`=0 after D.
- Core-to-driver turnaround: with `core_done` low at edge D+1, the next `core_start` rises after D+1. This gives a minimum one-cycle `start` low gap between entries.
- Timeout: an entry whose `done` never arrives occupies `TIMEOUT`+1 WAIT cycles plus 1 RELEASE cycle.
- Batch latency: the sum over entries of (core latency + 2), plus 1 FINISH cycle.

## Test plan
- Normal batch with the real sequential GCD core: load (24,16), (25,15), (7,13), (100,75) and pulse `go`. Required: `rd_gcd` reads 8, 5, 1, 25; all `rd_err`=0; `err_count`=0; exactly one `finished` pulse; `core_start` low for ≥1 cycle between entries.
- Timeout: core model never asserts `done`, `TIMEOUT`=20. Required: each entry spends 21 WAIT cycles; all `rd_err`=1 and `rd_gcd`=0; `err_count`=4; `finished` pulses.
- Sticky `done`: core model holds `done` high for 5 cycles after each result. Required: driver stays in RELEASE with `core_start`=0 until `done` falls; each result captured once; results match.
- Ignored controls: `go` and `load` (addr 0, (9,3)) asserted mid-batch. Required: no restart; operand 0 unchanged (a later batch still yields 8 for entry 0).
- Reset mid-WAIT: assert `rst` while `core_start`=1 on entry 2. Required: `core_start`, `busy` and `err_count` are 0 immediately (before the next edge); all tables read 0; a new load+`go` batch then completes correctly.
- Mixed: entry 1 model hangs while the others respond. Required: `rd_err`=0,1,0,0; `err_count`=1; valid results in entries 0, 2 and 3.
